// File: rtl/alu_fifo_core_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_fifo_core_if
// Description : Switch/button inputs and display outputs of alu_fifo_core.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_fifo_core_if #(
  parameter int W     = 6,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          button;
  logic          mode;
  logic [2:0]    instruct;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [2:0]    dout_op;
  logic [W-1:0]  dout_res;
  logic          dout_ovf;
  logic          dout_valid;
  logic          nA_LED;
  logic          nB_LED;
  logic          nR_LED;
  logic          over_LED;
  logic          LED_full;
  logic          LED_empty;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          err_ovr;
  logic          err_udr;

  modport master (
    output button, mode, instruct, A, B,
    input  dout_op, dout_res, dout_ovf, dout_valid, nA_LED, nB_LED, nR_LED,
           over_LED, LED_full, LED_empty, almost_full, count, err_ovr, err_udr
  );

  modport slave (
    input  button, mode, instruct, A, B,
    output dout_op, dout_res, dout_ovf, dout_valid, nA_LED, nB_LED, nR_LED,
           over_LED, LED_full, LED_empty, almost_full, count, err_ovr, err_udr
  );
endinterface
`default_nettype wire

// File: rtl/alu_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_fifo_core
// Description : Signed W-bit ALU feeding a DEPTH-entry FIFO, button driven.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_fifo_core #(
  parameter int W         = 6,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  wire logic       clock,
  input  wire logic       rst,
  alu_fifo_core_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 3 + W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sync_q;
  logic            strobe;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q, b_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [2:0]      dout_op_q;
  logic [W-1:0]    dout_res_q;
  logic            dout_ovf_q, dout_valid_q;
  logic            err_ovr_q, err_udr_q;
  logic            capture, exec, pop_req;
  logic            full, empty, push, pop;
  logic [W-1:0]    sum, diff, res;
  logic            ovf;
  logic [EW-1:0]   head;

  // sync_q[1] is the synchronised level; sync_q[2] delays it for edge detect
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[1:0], bus.button};
  end
  assign strobe = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    exec    = 1'b0;
    pop_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (bus.mode) begin
            capture = 1'b1;
            state_d = EXEC;
          end else begin
            pop_req = 1'b1;
          end
        end
      end
      EXEC: begin
        exec    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = exec & ~full;
  assign pop   = pop_req & ~empty;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op_q)
      3'b000: begin
        res = sum;
        ovf = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      3'b001: begin
        res = diff;
        ovf = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      3'b010:  res = a_q & b_q;
      3'b011:  res = a_q | b_q;
      3'b100:  res = {{(W-1){1'b0}}, (a_q == b_q)};
      3'b101:  res = {{(W-1){1'b0}}, ($signed(a_q) > $signed(b_q))};
      3'b110:  res = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: res = {{(W-1){1'b0}}, (a_q == '0)};
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (capture) begin
      op_q <= bus.instruct;
      a_q  <= bus.A;
      b_q  <= bus.B;
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {op_q, res, ovf};
  end
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_op_q    <= '0;
      dout_res_q   <= '0;
      dout_ovf_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      err_ovr_q    <= 1'b0;
      err_udr_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        count_q  <= count_q + CW'(1);
      end else if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PW'(1);
        count_q      <= count_q - CW'(1);
        dout_op_q    <= head[EW-1 -: 3];
        dout_res_q   <= head[W:1];
        dout_ovf_q   <= head[0];
        dout_valid_q <= 1'b1;
      end
      if (exec && full)     err_ovr_q <= 1'b1;
      if (pop_req && empty) err_udr_q <= 1'b1;
    end
  end

  assign bus.dout_op     = dout_op_q;
  assign bus.dout_res    = dout_res_q;
  assign bus.dout_ovf    = dout_ovf_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.nA_LED      = bus.A[W-1];
  assign bus.nB_LED      = bus.B[W-1];
  assign bus.nR_LED      = dout_res_q[W-1] & dout_valid_q;
  assign bus.over_LED    = dout_ovf_q & dout_valid_q;
  assign bus.LED_full    = full;
  assign bus.LED_empty   = empty;
  assign bus.almost_full = (count_q >= CW'(AF_THRESH));
  assign bus.count       = count_q;
  assign bus.err_ovr     = err_ovr_q;
  assign bus.err_udr     = err_udr_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_fifo_core
// Description : Directed, table-driven bench for alu_fifo_core (W=6, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_fifo_core;
  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  alu_fifo_core_if #(.W(6), .DEPTH(8)) bus ();
  alu_fifo_core #(.W(6), .DEPTH(8), .AF_THRESH(7)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] res;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic m, input logic [2:0] op, input logic [5:0] a,
                       input logic [5:0] b);
    @(negedge clock);
    bus.mode = m; bus.instruct = op; bus.A = a; bus.B = b; bus.button = 1'b1;
    repeat (3) @(negedge clock);
    bus.button = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b);
    press(1'b1, op, a, b);
  endtask

  task automatic rd();
    press(1'b0, 3'b000, 6'h00, 6'h00);
  endtask

  initial begin
    vecs[0]  = '{"and",      3'b010, 6'h2A, 6'h0F, 6'h0A, 1'b0};
    vecs[1]  = '{"or",       3'b011, 6'h21, 6'h06, 6'h27, 1'b0};
    vecs[2]  = '{"sub_ovf",  3'b001, 6'h20, 6'h01, 6'h1F, 1'b1};
    vecs[3]  = '{"add_ovf",  3'b000, 6'h20, 6'h20, 6'h00, 1'b1};
    vecs[4]  = '{"sub_ovf2", 3'b001, 6'h00, 6'h20, 6'h20, 1'b1};
    vecs[5]  = '{"gt_true",  3'b101, 6'h05, 6'h3D, 6'h01, 1'b0};
    vecs[6]  = '{"lt_false", 3'b110, 6'h05, 6'h3D, 6'h00, 1'b0};
    vecs[7]  = '{"eq_false", 3'b100, 6'h03, 6'h04, 6'h00, 1'b0};
    vecs[8]  = '{"zero_f",   3'b111, 6'h01, 6'h00, 6'h00, 1'b0};
    vecs[9]  = '{"add_pos",  3'b000, 6'h0C, 6'h07, 6'h13, 1'b0};
    vecs[10] = '{"sub_neg",  3'b001, 6'h03, 6'h08, 6'h3B, 1'b0};
    vecs[11] = '{"gt_eq",    3'b101, 6'h3D, 6'h3D, 6'h00, 1'b0};

    bus.button = 1'b0; bus.mode = 1'b0; bus.instruct = 3'b000;
    bus.A = 6'h00; bus.B = 6'h00;
    repeat (3) @(negedge clock);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.LED_empty, 1);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_res", bus.dout_res, 0);
    rst = 1'b1;
    repeat (2) @(negedge clock);

    // -5 + -7
    wr(3'b000, 6'h3B, 6'h39);
    chk("add1_count", bus.count, 1);
    chk("add1_empty", bus.LED_empty, 0);
    rd();
    chk("add1_res", bus.dout_res, 6'h34);
    chk("add1_ovf", bus.dout_ovf, 0);
    chk("add1_nR", bus.nR_LED, 1);
    chk("add1_op", bus.dout_op, 3'b000);
    chk("add1_valid", bus.dout_valid, 1);
    chk("add1_count0", bus.count, 0);
    chk("add1_empty1", bus.LED_empty, 1);

    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].op, vecs[i].a, vecs[i].b);
      rd();
      chk({vecs[i].name, "_res"}, bus.dout_res, vecs[i].res);
      chk({vecs[i].name, "_ovf"}, bus.dout_ovf, vecs[i].ovf);
      chk({vecs[i].name, "_op"}, bus.dout_op, vecs[i].op);
      chk({vecs[i].name, "_overled"}, bus.over_LED, vecs[i].ovf);
    end

    wr(3'b001, 6'h1E, 6'h06);
    wr(3'b000, 6'h1F, 6'h01);
    chk("pair_count", bus.count, 2);
    rd();
    chk("sub_res", bus.dout_res, 6'h18);
    chk("sub_ovf", bus.dout_ovf, 0);
    rd();
    chk("add31_res", bus.dout_res, 6'h20);
    chk("add31_ovf", bus.dout_ovf, 1);
    chk("add31_overled", bus.over_LED, 1);

    wr(3'b100, 6'h17, 6'h17);
    wr(3'b101, 6'h23, 6'h1B);
    wr(3'b110, 6'h33, 6'h0E);
    wr(3'b111, 6'h00, 6'h15);
    rd(); chk("cmp_eq", bus.dout_res, 1);
    rd(); chk("cmp_gt", bus.dout_res, 0);
    rd(); chk("cmp_lt", bus.dout_res, 1);
    rd(); chk("cmp_zero", bus.dout_res, 1);

    @(negedge clock);
    bus.A = 6'h20; bus.B = 6'h1F;
    #1;
    chk("nA_LED", bus.nA_LED, 1);
    chk("nB_LED", bus.nB_LED, 0);

    // Fill to capacity, then overrun and underrun
    chk("pre_ovr", bus.err_ovr, 0);
    chk("pre_udr", bus.err_udr, 0);
    for (int i = 1; i <= 8; i++) begin
      wr(3'b000, 6'(i), 6'h00);
      chk($sformatf("fill_count%0d", i), bus.count, i);
      chk($sformatf("fill_af%0d", i), bus.almost_full, (i >= 7));
      chk($sformatf("fill_full%0d", i), bus.LED_full, (i == 8));
    end
    wr(3'b000, 6'h14, 6'h00);
    chk("ovr_flag", bus.err_ovr, 1);
    chk("ovr_count", bus.count, 8);
    for (int i = 1; i <= 8; i++) begin
      rd();
      chk($sformatf("drain_res%0d", i), bus.dout_res, i);
    end
    chk("drain_empty", bus.LED_empty, 1);
    rd();
    chk("udr_flag", bus.err_udr, 1);
    chk("udr_res", bus.dout_res, 8);
    chk("udr_count", bus.count, 0);
    chk("ovr_sticky", bus.err_ovr, 1);

    // Held button gives a single push
    @(negedge clock);
    bus.mode = 1'b1; bus.instruct = 3'b000; bus.A = 6'h03; bus.B = 6'h04;
    bus.button = 1'b1;
    repeat (20) @(negedge clock);
    bus.button = 1'b0;
    repeat (4) @(negedge clock);
    chk("hold_count", bus.count, 1);
    rd();
    chk("hold_res", bus.dout_res, 6'h07);
    chk("hold_count0", bus.count, 0);

    // Operand change during EXEC must not affect the push
    @(negedge clock);
    bus.mode = 1'b1; bus.instruct = 3'b000; bus.A = 6'h0A; bus.B = 6'h01;
    bus.button = 1'b1;
    repeat (3) @(posedge clock);
    #1 bus.A = 6'h14;
    @(negedge clock);
    bus.button = 1'b0;
    repeat (4) @(negedge clock);
    chk("cap_count", bus.count, 1);
    rd();
    chk("cap_res", bus.dout_res, 6'h0B);

    // Reset while in EXEC discards the pending entry
    @(negedge clock);
    bus.mode = 1'b1; bus.instruct = 3'b000; bus.A = 6'h05; bus.B = 6'h05;
    bus.button = 1'b1;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    #2;
    chk("mrst_count", bus.count, 0);
    chk("mrst_valid", bus.dout_valid, 0);
    chk("mrst_ovr", bus.err_ovr, 0);
    chk("mrst_udr", bus.err_udr, 0);
    @(negedge clock);
    bus.button = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b1;
    repeat (4) @(negedge clock);
    chk("post_count", bus.count, 0);
    chk("post_empty", bus.LED_empty, 1);
    chk("post_res", bus.dout_res, 0);
    rd();
    chk("post_udr", bus.err_udr, 1);
    chk("post_valid", bus.dout_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
